// File: rtl/bram_sdp_stream_reader.sv
// bram_sdp_stream_reader
// Read engine for a simple dual-port BRAM with a one-cycle registered read.
// It takes a (start address, length) command and streams that many
// consecutive words out on a valid/ready interface. A 4-entry buffer absorbs
// the RAM read latency.
//
// Ports
//   clk, rst_n            clock shared with the BRAM; async active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_addr = first word,
//                         cmd_len = word count (0 is accepted and ignored)
//   ram_read_addr, ram_q  BRAM read port (q answers last cycle's address)
//   out_valid/out_ready   output stream handshake; out_data = word,
//                         out_last = final word of the command
//   busy                  a command is in progress
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing reads while the buffer has credit
// DRAIN | all reads issued, waiting for the last word to leave
`timescale 1ns/1ps
module bram_sdp_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int DEPTH = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic [1:0]            rst_sync;
    logic                  rst_int;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  pend;
    logic                  pend_last;
    logic [DATA_WIDTH-1:0] buf_data [DEPTH];
    logic                  buf_last [DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            occ;
    logic                  cmd_fire;
    logic                  issue;
    logic                  last_issue;
    logic                  push;
    logic                  pop;

    // Reset asserts immediately and releases two edges later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int = rst_sync[1];

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cmd_fire  = cmd_valid && (state == IDLE);

    // Credit counts the word still in flight from the RAM, so the buffer can
    // never overflow. Only registered terms are used: no path from out_ready.
    assign issue      = (state == RUN) && ((occ + {2'b00, pend}) < 3'd4);
    assign last_issue = issue && (remaining == (ADDR_WIDTH+1)'(1));
    assign push       = pend;
    assign pop        = out_valid && out_ready;

    // The RAM registers its address, so the issue address goes out
    // combinationally. This keeps the first word one cycle earlier.
    assign ram_read_addr = issue ? addr_cnt : addr_hold;

    assign out_valid = (occ != 3'd0);
    assign out_data  = buf_data[rd_ptr];
    assign out_last  = out_valid && buf_last[rd_ptr];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire && (cmd_len != '0)) state_next = RUN;
            RUN:     if (last_issue)                  state_next = DRAIN;
            DRAIN:   if (pop && out_last)             state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            addr_hold <= '0;
            remaining <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            occ       <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            state     <= state_next;
            pend      <= issue;
            pend_last <= last_issue;
            if (cmd_fire) begin
                addr_cnt  <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue) begin
                addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH+1)'(1);
            end
            if (issue) addr_hold <= addr_cnt;
            if (push) begin
                buf_data[wr_ptr] <= ram_q;
                buf_last[wr_ptr] <= pend_last;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            occ <= occ + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_int && push) assert (occ != 3'd4);
    end

endmodule

// File: tb/tb_bram_sdp_stream_reader.sv
`timescale 1ns/1ps
module tb_bram_sdp_stream_reader;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int RAM_DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_q;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    logic [DW-1:0] mem [RAM_DEPTH];

    int checks = 0;
    int errors = 0;

    bram_sdp_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_read_addr(ram_read_addr), .ram_q(ram_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // BRAM read port: one-cycle registered read
    always @(posedge clk) ram_q <= mem[ram_read_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected stream: word i of a command is mem[(addr+i) mod depth],
    // flagged last when i == len-1. With ready held high the i-th word is
    // visible in cycle N+3+i, N being the handshake cycle.
    task automatic run_cmd(input int addr, input int len, input bit rand_ready);
        int            got;
        bit            done;
        bit            stalled;
        logic [DW-1:0] held_d;
        logic          held_l;
        got = 0; done = 0; stalled = 0; held_d = '0; held_l = 1'b0;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW+1)'(len);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 600 && !done; k++) begin
            @(negedge clk);
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (k == 1) chk("busy_after_accept", busy, 1);
            if (!rand_ready) chk("valid_timing", out_valid, (k >= 3 && k < 3 + len) ? 1 : 0);
            if (stalled) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_stable", out_data, held_d);
                chk("stall_last_stable", out_last, held_l);
            end
            stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    chk("data", out_data, mem[(addr + got) % RAM_DEPTH]);
                    chk("last", out_last, (got == len - 1) ? 1 : 0);
                    got++;
                    if (got == len) done = 1;
                end else begin
                    stalled = 1;
                    held_d  = out_data;
                    held_l  = out_last;
                end
            end
        end
        if (!done) chk("burst_complete", got, len);
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_cmd_ready", cmd_ready, 1);
        chk("end_valid", out_valid, 0);
    endtask

    initial begin
        int got;
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = DW'(i) ^ 8'hA5;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ram_addr", ram_read_addr, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_no_output", out_valid, 0);
        end

        run_cmd(5, 4, 0);    // A0 A3 A2 AD
        run_cmd(62, 4, 0);   // wrap: 9B 9A A5 A4
        run_cmd(0, 16, 1);   // backpressure
        run_cmd(0, 64, 0);   // full depth, back-to-back
        for (int r = 0; r < 4; r++)
            run_cmd(int'($urandom_range(0, RAM_DEPTH - 1)), int'($urandom_range(1, 20)), 1);

        // len == 0 is accepted and produces nothing
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 6'd3; cmd_len = '0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("len0_busy", busy, 0);
            chk("len0_valid", out_valid, 0);
            chk("len0_cmd_ready", cmd_ready, 1);
        end

        // Reset pulsed mid-burst after three words
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 6'd20; cmd_len = 7'd8;
        out_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 50 && got < 3; k++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("pre_reset_data", out_data, mem[(20 + got) % RAM_DEPTH]);
                got++;
            end
        end
        chk("pre_reset_words", got, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_data", out_data, 0);
        chk("midrst_ram_addr", ram_read_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset_no_output", out_valid, 0);
        end
        run_cmd(10, 2, 0);   // AF AE

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
